maxnet_winner_detect: RTL and testbench

//   Sits downstream of the four-lane Maxnet value registers and watches x1..x4 after every update step.

---
 rtl/maxnet_pkg.sv | 17 +
 rtl/lane_nonzero_enc.sv | 41 ++++
 rtl/maxnet_winner_detect.sv | 157 +++++++++++++++
 tb/tb_maxnet_winner_detect.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// maxnet_pkg
//   Shared definitions for the Maxnet winner detector and its controller:
//   FSM state encoding, lane count, lane index type and iteration counter width.
package maxnet_pkg;

  localparam int LANES  = 4;
  localparam int ITER_W = 8;

  typedef logic [1:0] lane_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } maxnet_state_t;

endpackage

// File: rtl/lane_nonzero_enc.sv
// lane_nonzero_enc
//   Combinational classifier for the four Maxnet lanes. Takes only the
//   magnitude bits (sign stripped), so +0 and -0 both read as zero.
// Ports
//   i_mag1..i_mag4  in   WIDTH-1  lane magnitudes (lane value without sign bit)
//   o_nz_cnt        out  3        number of nonzero lanes (0..4)
//   o_low_idx       out  2        lowest-index nonzero lane (0 when none)
//   o_one_hot       out  1        exactly one lane is nonzero
module lane_nonzero_enc
  import maxnet_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-2:0] i_mag1,
  input  logic [WIDTH-2:0] i_mag2,
  input  logic [WIDTH-2:0] i_mag3,
  input  logic [WIDTH-2:0] i_mag4,
  output logic [2:0]       o_nz_cnt,
  output lane_idx_t        o_low_idx,
  output logic             o_one_hot
);

  logic [LANES-1:0] w_nz;

  assign w_nz[0] = |i_mag1;
  assign w_nz[1] = |i_mag2;
  assign w_nz[2] = |i_mag3;
  assign w_nz[3] = |i_mag4;

  assign o_nz_cnt = 3'(w_nz[0]) + 3'(w_nz[1]) + 3'(w_nz[2]) + 3'(w_nz[3]);
  assign o_one_hot = (o_nz_cnt == 3'd1);

  always_comb begin
    o_low_idx = 2'd0;
    if (w_nz[0])      o_low_idx = 2'd0;
    else if (w_nz[1]) o_low_idx = 2'd1;
    else if (w_nz[2]) o_low_idx = 2'd2;
    else if (w_nz[3]) o_low_idx = 2'd3;
  end

endmodule

// File: rtl/maxnet_winner_detect.sv
// maxnet_winner_detect
//   Watches the four Maxnet lanes after each update step and detects
//   convergence (single survivor -> winner, all zero -> no winner, optional
//   iteration limit -> timeout). The result is latched, o_halt stops the
//   controller, and the result is offered on a valid/ready handshake.
// Configuration
//   MAXNET_TIMEOUT_EN  when defined, a run with >=2 live lanes at step
//                      MAX_ITER ends with o_timeout=1. When undefined the run
//                      continues indefinitely and o_timeout stays 0.
// Ports
//   i_clk           in   1      clock, rising edge
//   i_rst           in   1      synchronous active-low reset
//   i_start         in   1      begin a new run
//   i_step          in   1      lanes hold freshly updated values
//   i_x1..i_x4      in   WIDTH  lane values (IEEE-754, MSB = sign)
//   o_halt          out  1      registered; high while a result is held
//   o_out_valid     out  1      result available
//   i_out_ready     in   1      consumer accepts result
//   o_winner_value  out  WIDTH  latched value of winning lane
//   o_winner_idx    out  2      winning lane 0..3
//   o_no_winner     out  1      all lanes reached zero
//   o_timeout       out  1      iteration limit reached with >1 lane live
//   o_iter_count    out  8      steps in current/last run, saturating
module maxnet_winner_detect
  import maxnet_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MAX_ITER = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_step,
  input  logic [WIDTH-1:0]  i_x1,
  input  logic [WIDTH-1:0]  i_x2,
  input  logic [WIDTH-1:0]  i_x3,
  input  logic [WIDTH-1:0]  i_x4,
  output logic              o_halt,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [WIDTH-1:0]  o_winner_value,
  output lane_idx_t         o_winner_idx,
  output logic              o_no_winner,
  output logic              o_timeout,
  output logic [ITER_W-1:0] o_iter_count
);

  localparam logic [ITER_W-1:0] ITER_MAX  = '1;
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);

  maxnet_state_t     r_state;
  maxnet_state_t     w_state_next;
  logic              r_halt;
  logic [WIDTH-1:0]  r_winner_value;
  lane_idx_t         r_winner_idx;
  logic              r_no_winner;
  logic              r_timeout;
  logic [ITER_W-1:0] r_iter_count;

  logic [2:0]        w_nz_cnt;
  lane_idx_t         w_low_idx;
  logic              w_one_hot;
  logic              w_timeout_hit;
  logic [WIDTH-1:0]  w_sel_value;

  lane_nonzero_enc #(.WIDTH(WIDTH)) u_enc (
    .i_mag1    (i_x1[WIDTH-2:0]),
    .i_mag2    (i_x2[WIDTH-2:0]),
    .i_mag3    (i_x3[WIDTH-2:0]),
    .i_mag4    (i_x4[WIDTH-2:0]),
    .o_nz_cnt  (w_nz_cnt),
    .o_low_idx (w_low_idx),
    .o_one_hot (w_one_hot)
  );

  // Both the single-survivor and timeout cases report the lowest live lane.
  always_comb begin
    case (w_low_idx)
      2'd0:    w_sel_value = i_x1;
      2'd1:    w_sel_value = i_x2;
      2'd2:    w_sel_value = i_x3;
      default: w_sel_value = i_x4;
    endcase
  end

`ifdef MAXNET_TIMEOUT_EN
  // This step is step number MAX_ITER and at least two lanes are still live.
  assign w_timeout_hit = (r_iter_count == ITER_LAST) && (w_nz_cnt >= 3'd2);
`else
  // Limit disabled; ITER_LAST is referenced only so the parameter stays used.
  assign w_timeout_hit = 1'b0 & (ITER_LAST == '0);
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_state_next = ST_RUN;
      ST_RUN: begin
        if (i_start)
          w_state_next = ST_RUN;
        else if (i_step && (w_nz_cnt == 3'd0 || w_one_hot || w_timeout_hit))
          w_state_next = ST_HOLD;
      end
      ST_HOLD: begin
        // A start without out_ready is dropped so the held result is not lost.
        if (i_out_ready) w_state_next = i_start ? ST_RUN : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_halt         <= 1'b0;
      r_winner_value <= '0;
      r_winner_idx   <= '0;
      r_no_winner    <= 1'b0;
      r_timeout      <= 1'b0;
      r_iter_count   <= '0;
    end else begin
      r_halt <= (w_state_next == ST_HOLD);
      if ((r_state == ST_IDLE && i_start) || (r_state == ST_RUN && i_start) ||
          (r_state == ST_HOLD && i_start && i_out_ready)) begin
        r_winner_value <= '0;
        r_winner_idx   <= '0;
        r_no_winner    <= 1'b0;
        r_timeout      <= 1'b0;
        r_iter_count   <= '0;
      end else if (r_state == ST_RUN && i_step) begin
        if (r_iter_count != ITER_MAX) r_iter_count <= r_iter_count + 1'b1;
        if (w_one_hot || w_timeout_hit) begin
          r_winner_value <= w_sel_value;
          r_winner_idx   <= w_low_idx;
          r_timeout      <= w_timeout_hit;
        end else if (w_nz_cnt == 3'd0) begin
          r_winner_value <= '0;
          r_winner_idx   <= '0;
          r_no_winner    <= 1'b1;
        end
      end
    end
  end

  assign o_halt         = r_halt;
  assign o_out_valid    = (r_state == ST_HOLD);
  assign o_winner_value = r_winner_value;
  assign o_winner_idx   = r_winner_idx;
  assign o_no_winner    = r_no_winner;
  assign o_timeout      = r_timeout;
  assign o_iter_count   = r_iter_count;

endmodule

// File: tb/tb_maxnet_winner_detect.sv
module tb_maxnet_winner_detect;
  import maxnet_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        step = 1'b0;
  logic [31:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0;
  logic        out_ready = 1'b0;
  logic        halt, out_valid, no_winner, timeout;
  logic [31:0] winner_value;
  lane_idx_t   winner_idx;
  logic [7:0]  iter_count;

  int errors = 0;
  int checks = 0;

  maxnet_winner_detect #(.WIDTH(32), .MAX_ITER(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_step         (step),
    .i_x1           (x1),
    .i_x2           (x2),
    .i_x3           (x3),
    .i_x4           (x4),
    .o_halt         (halt),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_winner_value (winner_value),
    .o_winner_idx   (winner_idx),
    .o_no_winner    (no_winner),
    .o_timeout      (timeout),
    .o_iter_count   (iter_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lanes(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] d);
    x1 = a; x2 = b; x3 = c; x4 = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_halt"},  32'(halt), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_value"}, winner_value, 0);
    chk({tag, "_idx"},   32'(winner_idx), 0);
    chk({tag, "_nowin"}, 32'(no_winner), 0);
    chk({tag, "_tmo"},   32'(timeout), 0);
    chk({tag, "_iter"},  32'(iter_count), 0);
  endtask

  initial begin
    // reset
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b1;

    // 1: single nonzero lane x3
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1; lanes(32'h0, 32'h0, 32'h3F800000, 32'h0); tick(); step = 1'b0;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_halt",  32'(halt), 1);
    chk("t1_idx",   32'(winner_idx), 2);
    chk("t1_value", winner_value, 32'h3F800000);
    chk("t1_iter",  32'(iter_count), 1);
    chk("t1_nowin", 32'(no_winner), 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t1_rel_valid", 32'(out_valid), 0);
    chk("t1_rel_halt",  32'(halt), 0);
    chk("t1_rel_value", winner_value, 32'h3F800000);
    chk("t1_rel_iter",  32'(iter_count), 1);

    // 2: three multi-lane steps then a single survivor with -0 on x4
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1;
    lanes(32'h3F800000, 32'h40000000, 32'h0, 32'h0); tick();
    chk("t2_s1_valid", 32'(out_valid), 0);
    lanes(32'h0, 32'h0, 32'h00000005, 32'h00000005); tick();
    chk("t2_s2_valid", 32'(out_valid), 0);
    lanes(32'h80000001, 32'h0, 32'h00000001, 32'h0); tick();
    chk("t2_s3_valid", 32'(out_valid), 0);
    chk("t2_s3_iter",  32'(iter_count), 3);
    lanes(32'h0, 32'h40000000, 32'h0, 32'h80000000); tick(); step = 1'b0;
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_idx",   32'(winner_idx), 1);
    chk("t2_value", winner_value, 32'h40000000);
    chk("t2_iter",  32'(iter_count), 4);
    chk("t2_tmo",   32'(timeout), 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 3: all lanes zero (one as -0)
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1; lanes(32'h0, 32'h80000000, 32'h0, 32'h0); tick(); step = 1'b0;
    chk("t3_valid", 32'(out_valid), 1);
    chk("t3_nowin", 32'(no_winner), 1);
    chk("t3_value", winner_value, 0);
    chk("t3_idx",   32'(winner_idx), 0);
    chk("t3_iter",  32'(iter_count), 1);

    // 4: hold without ready; start and step must be ignored
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      step  = (i == 2);
      lanes(32'h0, 32'h0, 32'h0, (i == 2) ? 32'h3F800000 : 32'h0);
      tick();
      chk("t4_hold_valid", 32'(out_valid), 1);
      chk("t4_hold_halt",  32'(halt), 1);
      chk("t4_hold_nowin", 32'(no_winner), 1);
      chk("t4_hold_iter",  32'(iter_count), 1);
    end
    start = 1'b0; step = 1'b0;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t4_rel_valid", 32'(out_valid), 0);
    chk("t4_rel_halt",  32'(halt), 0);
    chk("t4_rel_nowin", 32'(no_winner), 1);
    step = 1'b1; lanes(32'h0, 32'h3F800000, 32'h0, 32'h0); tick(); step = 1'b0;
    chk("t4_idle_valid", 32'(out_valid), 0);
    chk("t4_idle_iter",  32'(iter_count), 1);
    chk("t4_idle_nowin", 32'(no_winner), 1);

    // 5: iteration limit with MAX_ITER=4
    start = 1'b1; tick(); start = 1'b0;
    step = 1'b1; lanes(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    tick(); tick(); tick();
    chk("t5_s3_valid", 32'(out_valid), 0);
    tick(); step = 1'b0;
`ifdef MAXNET_TIMEOUT_EN
    chk("t5_valid", 32'(out_valid), 1);
    chk("t5_tmo",   32'(timeout), 1);
    chk("t5_idx",   32'(winner_idx), 0);
    chk("t5_value", winner_value, 32'h3F800000);
    chk("t5_iter",  32'(iter_count), 4);
    // start together with ready goes straight back to RUN
    start = 1'b1; out_ready = 1'b1; tick(); start = 1'b0; out_ready = 1'b0;
`else
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_tmo",   32'(timeout), 0);
    chk("t5_iter",  32'(iter_count), 4);
    chk("t5_halt",  32'(halt), 0);
    // restart in RUN; the step in the same cycle is ignored
    start = 1'b1; step = 1'b1; lanes(32'h0, 32'h0, 32'h3F800000, 32'h0);
    tick(); start = 1'b0; step = 1'b0;
`endif
    chk("t5_rs_valid", 32'(out_valid), 0);
    chk("t5_rs_iter",  32'(iter_count), 0);
    chk("t5_rs_tmo",   32'(timeout), 0);
    chk("t5_rs_value", winner_value, 0);

    // 6: reset mid-run after two steps
    step = 1'b1; lanes(32'h3F800000, 32'h40000000, 32'h0, 32'h0);
    tick(); tick(); step = 1'b0;
    chk("t6_pre_iter", 32'(iter_count), 2);
    rst = 1'b0; tick(); rst = 1'b1;
    chk_all_zero("t6_rst");
    step = 1'b1; lanes(32'h0, 32'h0, 32'h0, 32'h40000000); tick(); step = 1'b0;
    chk("t6_idle_valid", 32'(out_valid), 0);
    chk("t6_idle_iter",  32'(iter_count), 0);
    chk("t6_idle_value", winner_value, 0);
    tick();
    chk("t6_idle_halt",  32'(halt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
